// File: rtl/usb_pkg.sv
// Shared types and constants for the USB serial bit stuffer and its optional NRZI line encoder.
package usb_pkg;

  localparam int   STUFF_LEN_DEFAULT = 6;
  localparam int   RUN_W             = 4;
  localparam logic NRZI_IDLE_LEVEL   = 1'b1;

  typedef enum logic {
    PASS,
    STUFF
  } stuff_state_t;

  // Length of the run of 1s after one more data bit; saturates so it can never wrap.
  function automatic logic [RUN_W-1:0] run_step(input logic [RUN_W-1:0] run,
                                                input logic             one);
    if (!one) begin
      return '0;
    end
    if (run == '1) begin
      return run;
    end
    return run + RUN_W'(1);
  endfunction

endpackage

// File: rtl/usb_nrzi_enc.sv
// NRZI line encoder: the level toggles on every emitted 0 and holds on every emitted 1.
// Fed with the stuffer's next-state bit/valid so the line level is the output register itself.
module usb_nrzi_enc
  import usb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic bit_in,
  input  logic valid_in,
  output logic line_out
);

  logic level_q;
  logic level_d;

  always_comb begin
    level_d = level_q;
    if (valid_in && !bit_in) begin
      level_d = ~level_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= NRZI_IDLE_LEVEL;
    end else begin
      level_q <= level_d;
    end
  end

  assign line_out = level_q;

endmodule

// File: rtl/usb_bit_stuffer.sv
// USB bit stuffer: inserts a 0 after every STUFF_LEN consecutive 1s and stalls upstream for that slot.
// Build option USB_NRZI_EN: out_bit carries the NRZI line level instead of the raw stuffed bit.
module usb_bit_stuffer
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic pkt_start,
  input  logic in_bit,
  input  logic in_valid,
  input  logic in_eop,
  output logic bs_ready,
  output logic out_bit,
  output logic out_valid,
  output logic out_eop
);

  localparam logic [RUN_W-1:0] STUFF_RUN = RUN_W'(STUFF_LEN);

  stuff_state_t     state_q;
  stuff_state_t     state_d;
  logic [RUN_W-1:0] ones_cnt_q;
  logic [RUN_W-1:0] ones_cnt_d;
  logic [RUN_W-1:0] run_base;
  logic [RUN_W-1:0] run_next;
  logic             bs_ready_q;
  logic             bs_ready_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             out_eop_q;
  logic             out_eop_d;
  logic             out_bit_d;
  logic             stuff_eop_q;
  logic             stuff_eop_d;
  logic             accept;

  assign accept = in_valid & bs_ready_q;

  // pkt_start clears the run before a same-cycle accepted bit is counted.
  assign run_base = pkt_start ? '0 : ones_cnt_q;
  assign run_next = run_step(run_base, in_bit);

  // NOTE: every signal gets a default at the top of always_comb so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d     = state_q;
    ones_cnt_d  = ones_cnt_q;
    bs_ready_d  = bs_ready_q;
    stuff_eop_d = stuff_eop_q;
    out_valid_d = 1'b0;
    out_eop_d   = 1'b0;
    out_bit_d   = 1'b0;

    unique case (state_q)
      PASS: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_bit_d   = in_bit;
          if (run_next == STUFF_RUN) begin
            // EOP is deferred to the stuff bit so the packet ends after the inserted 0.
            state_d     = STUFF;
            bs_ready_d  = 1'b0;
            stuff_eop_d = in_eop;
            ones_cnt_d  = run_next;
          end else begin
            out_eop_d  = in_eop;
            ones_cnt_d = in_eop ? '0 : run_next;
          end
        end else begin
          ones_cnt_d = run_base;
        end
      end

      STUFF: begin
        state_d     = PASS;
        bs_ready_d  = 1'b1;
        ones_cnt_d  = '0;
        stuff_eop_d = 1'b0;
        // A pkt_start here aborts the pending stuff bit instead of emitting it.
        if (!pkt_start) begin
          out_valid_d = 1'b1;
          out_bit_d   = 1'b0;
          out_eop_d   = stuff_eop_q;
        end
      end

      default: begin
        state_d    = PASS;
        bs_ready_d = 1'b1;
        ones_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= PASS;
      ones_cnt_q  <= '0;
      bs_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_eop_q   <= 1'b0;
      stuff_eop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_cnt_q  <= ones_cnt_d;
      bs_ready_q  <= bs_ready_d;
      out_valid_q <= out_valid_d;
      out_eop_q   <= out_eop_d;
      stuff_eop_q <= stuff_eop_d;
    end
  end

`ifdef USB_NRZI_EN
  usb_nrzi_enc u_nrzi_enc (
    .clock    (clock),
    .reset    (reset),
    .bit_in   (out_bit_d),
    .valid_in (out_valid_d),
    .line_out (out_bit)
  );
`else
  logic out_bit_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_bit_q <= 1'b0;
    end else begin
      out_bit_q <= out_bit_d;
    end
  end

  assign out_bit = out_bit_q;
`endif

  assign bs_ready  = bs_ready_q;
  assign out_valid = out_valid_q;
  assign out_eop   = out_eop_q;

endmodule
